// File: rtl/memory_arbiter_pkg.sv
// Shared CPU-side definitions: arbiter FSM state, memory owner encoding and
// the default bus widths used by the controller, datapath and arbiter.
package cpu_package;

    localparam int DEFAULT_DATA_WIDTH    = 16;
    localparam int DEFAULT_ADDRESS_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_CPU   = 1'b0,
        OWNER_VIDEO = 1'b1
    } owner_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of CPU, video and memory-macro signals around the memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface memory_arbiter_if
    import cpu_package::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
);

    logic                     cpu_request;
    logic                     cpu_write_enable;
    logic [ADDRESS_WIDTH-1:0] cpu_address;
    logic [DATA_WIDTH-1:0]    cpu_write_data;
    logic [DATA_WIDTH-1:0]    cpu_read_data;
    logic                     cpu_acknowledge;

    logic                     video_request;
    logic [ADDRESS_WIDTH-1:0] video_address;
    logic [DATA_WIDTH-1:0]    video_read_data;
    logic                     video_acknowledge;

    logic [ADDRESS_WIDTH-1:0] memory_address;
    logic [DATA_WIDTH-1:0]    memory_write_data;
    logic                     memory_write_enable;
    logic [DATA_WIDTH-1:0]    memory_read_data;

    modport slave (
        input  cpu_request, cpu_write_enable, cpu_address, cpu_write_data,
        output cpu_read_data, cpu_acknowledge,
        input  video_request, video_address,
        output video_read_data, video_acknowledge,
        output memory_address, memory_write_data, memory_write_enable,
        input  memory_read_data
    );

    modport master (
        output cpu_request, cpu_write_enable, cpu_address, cpu_write_data,
        input  cpu_read_data, cpu_acknowledge,
        output video_request, video_address,
        input  video_read_data, video_acknowledge,
        input  memory_address, memory_write_data, memory_write_enable,
        output memory_read_data
    );

endinterface

// File: rtl/memory_arbiter.sv
// Shares the single-port memory between the CPU and video scan-out. CPU wins
// contention, but after CPU_RUN_LIMIT back-to-back CPU grants video gets a turn.
module memory_arbiter
    import cpu_package::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int CPU_RUN_LIMIT = 4
) (
    input logic              clock,
    input logic              reset,
    memory_arbiter_if.slave  bus
);

    localparam int RUN_WIDTH = $clog2(CPU_RUN_LIMIT + 1);
    localparam logic [RUN_WIDTH-1:0] RUN_MAX = RUN_WIDTH'(CPU_RUN_LIMIT);

    state_t               state, next_state;
    owner_t               owner, next_owner;
    logic [RUN_WIDTH-1:0] cpu_run, next_cpu_run;
    logic                 grant_video;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            owner   <= OWNER_CPU;
            cpu_run <= '0;
        end else begin
            state   <= next_state;
            owner   <= next_owner;
            cpu_run <= next_cpu_run;
        end
    end

    // Arbitration only happens in IDLE; a DONE cycle always returns to IDLE so
    // a requester that drops its request under acknowledge is never re-granted.
    always_comb begin
        next_state   = state;
        next_owner   = owner;
        next_cpu_run = cpu_run;
        grant_video  = bus.video_request && (!bus.cpu_request || cpu_run == RUN_MAX);
        case (state)
            IDLE: begin
                if (bus.cpu_request || bus.video_request) begin
                    next_state = ISSUE;
                    if (grant_video) begin
                        next_owner   = OWNER_VIDEO;
                        next_cpu_run = '0;
                    end else begin
                        next_owner = OWNER_CPU;
                        if (!bus.video_request)
                            next_cpu_run = '0;
                        else if (cpu_run != RUN_MAX)
                            next_cpu_run = cpu_run + RUN_WIDTH'(1);
                    end
                end
            end
            ISSUE:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.memory_address      = '0;
        bus.memory_write_data   = '0;
        bus.memory_write_enable = 1'b0;
        bus.cpu_acknowledge     = 1'b0;
        bus.video_acknowledge   = 1'b0;
        case (state)
            ISSUE: begin
                if (owner == OWNER_CPU) begin
                    bus.memory_address      = bus.cpu_address;
                    bus.memory_write_data   = bus.cpu_write_data;
                    bus.memory_write_enable = bus.cpu_write_enable;
                end else begin
                    bus.memory_address = bus.video_address;
                end
            end
            DONE: begin
                if (owner == OWNER_CPU)
                    bus.cpu_acknowledge = 1'b1;
                else
                    bus.video_acknowledge = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.cpu_read_data   = bus.memory_read_data;
    assign bus.video_read_data = bus.memory_read_data;

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single-port synchronous memory between the CPU controller (instruction fetch, load, store) and the video scan-out reader. The CPU has priority, and a bounded run counter guarantees the video port service. Each requester holds a request and sees a one-cycle acknowledge; the CPU controller stalls on that acknowledge. The block sits between the controller/datapath memory signals and the memory macro.

## Interface
- DATA_WIDTH, 16, memory word width.
- ADDRESS_WIDTH, 16, memory address width.
- CPU_RUN_LIMIT, 4, maximum consecutive CPU grants while video is waiting. Legal range is ≥1.
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- cpu_request  input  1  CPU access request; held high until cpu_acknowledge.
- cpu_write_enable  input  1  1 = store, 0 = read/fetch; stable while requesting.
- cpu_address  input  ADDRESS_WIDTH  CPU address; stable while requesting.
- cpu_write_data  input  DATA_WIDTH  store data; stable while requesting.
- cpu_read_data  output  DATA_WIDTH  read data; valid only while cpu_acknowledge is high.
- cpu_acknowledge  output  1  one-cycle pulse marking access completion.
- video_request  input  1  video read request; held until video_acknowledge.
- video_address  input  ADDRESS_WIDTH  video read address.
- video_read_data  output  DATA_WIDTH  read data; valid only while video_acknowledge is high.
- video_acknowledge  output  1  one-cycle completion pulse.
- memory_address  output  ADDRESS_WIDTH  to memory.
- memory_write_data  output  DATA_WIDTH  to memory.
- memory_write_enable  output  1  to memory.
- memory_read_data  input  DATA_WIDTH  from memory; registered, valid one cycle after the address.

## Operation
- FSM states: IDLE, ISSUE, DONE. Registers: `owner` (CPU/VIDEO) and `cpu_run` (width clog2(CPU_RUN_LIMIT+1)).
- IDLE: arbitration happens here.
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requesting: grant VIDEO if cpu_run == CPU_RUN_LIMIT, else grant CPU.
  - On a grant: latch owner and go to ISSUE.
- `cpu_run` update, at each grant:
  - CPU grant with video_request high: increment, saturating at CPU_RUN_LIMIT.
  - Any VIDEO grant: clear.
  - CPU grant with video_request low: clear.
- ISSUE: memory_address and memory_write_data are driven from the owner's inputs. memory_write_enable = cpu_write_enable when owner = CPU, else 0. Next state is DONE.
- DONE: assert owner's acknowledge; the owner's read_data carries memory_read_data. Memory outputs return to idle values. Next state is IDLE unconditionally, so a requester dropping its request in DONE is never re-granted.
- Idle memory outputs (IDLE/DONE): address 0, write data 0, memory_write_enable 0.
- Both read_data outputs are combinational copies of memory_read_data; consumers sample them only under acknowledge.
- Video never writes; video_address upper bits are passed unchanged.

## Timing
- Reset (reset low at an edge): state IDLE, owner CPU, cpu_run 0. All outputs 0: both acknowledges low, memory_write_enable low, memory_address 0.
- Latency: request seen in IDLE at cycle n → ISSUE at n+1 → acknowledge at n+2. One access every 3 cycles per port.
- Request rising during ISSUE/DONE: waits for the next IDLE. Worst-case video wait is 3·(CPU_RUN_LIMIT+1) cycles.
- Simultaneous requests in IDLE: resolved by the cpu_run rule in the same cycle, with no bubble.
- Reset asserted during ISSUE: the memory sees that cycle's write strobe, so the write commits (memory is not reset). No acknowledge is issued and the FSM returns to IDLE. Requesters must re-request after reset.
- Reset asserted during DONE: the acknowledge in that cycle remains valid and is counted as completed.
- Request deasserted before acknowledge is a protocol violation; behaviour is undefined and not checked.

## Structure
- Shared package (`cpu_package`): state encoding (IDLE/ISSUE/DONE), owner encoding, and DATA_WIDTH/ADDRESS_WIDTH defaults shared with the controller and datapath.
- Single module, no sub-modules. The arbitration decision is a combinational block feeding the FSM register; outputs are a combinational decode of state and owner.

## Test plan
- CPU read alone: mem[0x0010]=0xBEEF; cpu_request at cycle 0 with address 0x0010 → memory_address=0x0010 in cycle 1; cpu_acknowledge=1 with cpu_read_data=0xBEEF in cycle 2 only.
- CPU store then load: write 0x1234 to 0x0020, then read 0x0020 → memory_write_enable high exactly one cycle; read returns 0x1234.
- Contention, CPU_RUN_LIMIT=2, both requesting continuously → grant order CPU, CPU, VIDEO, CPU, CPU, VIDEO, with acknowledges every 3 cycles.
- Video alone at 0x8000 → video_acknowledge at cycle 2; memory_write_enable never high; cpu_acknowledge stays 0.
- Reset low during an ISSUE cycle of a CPU store → memory holds the new value; no cpu_acknowledge; all outputs 0 the next cycle; FSM in IDLE.
- Video request arrives while CPU is in ISSUE, with cpu_run = 0 → CPU completes, the next IDLE grants CPU if it is requesting, and cpu_run = 1.
